// File: rtl/spart_pkg.sv
// Shared SPART definitions: parity mode codes, transmitter state type and
// the parity helper used when a word is popped for transmission.
package spart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Parity over the low 'width' bits; odd parity is the inverted XOR.
  function automatic logic parity_bit(input logic [8:0] data,
                                      input int unsigned width,
                                      input int unsigned mode);
    logic [8:0] mask;
    mask = 9'((32'd1 << width) - 32'd1);
    return (^(data & mask)) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count; the count
// is what tells full from empty when the pointers coincide.
module spart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  // Fullness and emptiness are judged on the pre-cycle count.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spart_tx_param.sv
// SPART transmitter: FIFO-buffered writes serialised LSB-first as UART frames,
// one bit per baud tick, with back-to-back frames and sticky overrun.
module spart_tx_param
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_enable,
  input  logic                          write,
  input  logic [DATA_BITS-1:0]          tx_in,
  input  logic                          clr_overrun,
  output logic                          txd,
  output logic                          tbr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun
);

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS);
  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS);
  localparam bit         PAR_ON    = (PARITY_MODE != PAR_NONE);

  tx_state_e             state;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic [3:0]            bit_cnt;
  logic [1:0]            stop_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  head;
  logic                  frame_done;
  logic                  pop;

  spart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (write),
    .push_data (tx_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tbr  = !fifo_full;
  assign busy = (state != IDLE);

  // A pop happens exactly where the FSM loads a new frame: from IDLE or
  // from the last stop bit, so a waiting word starts with no idle gap.
  assign frame_done = (state == STOP) && (stop_cnt == STOP_LAST);
  assign pop        = tx_enable && !fifo_empty && ((state == IDLE) || frame_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
    end else if (tx_enable) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg   <= head;
            par_bit <= parity_bit(9'(head), DATA_BITS, PARITY_MODE);
            txd     <= 1'b0;
            state   <= START;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          txd     <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= 4'd1;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt < BIT_LAST) begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 4'd1;
          end else if (PAR_ON) begin
            txd   <= par_bit;
            state <= PARITY;
          end else begin
            txd      <= 1'b1;
            stop_cnt <= 2'd1;
            state    <= STOP;
          end
        end
        PARITY: begin
          txd      <= 1'b1;
          stop_cnt <= 2'd1;
          state    <= STOP;
        end
        STOP: begin
          if (stop_cnt < STOP_LAST) begin
            stop_cnt <= stop_cnt + 2'd1;
          end else if (!fifo_empty) begin
            shreg   <= head;
            par_bit <= parity_bit(9'(head), DATA_BITS, PARITY_MODE);
            txd     <= 1'b0;
            state   <= START;
          end else begin
            txd   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // A write refused because the FIFO is full outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (write && fifo_full) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_tx_param.sv
// Two transmitter configurations driven by shared stimulus and checked every
// cycle against a frame-level model, plus hand-computed line sequences.
module tb_spart_tx_param;

  localparam int DB0 = 8, PM0 = 0, SB0 = 1, FD0 = 4;
  localparam int DB1 = 7, PM1 = 2, SB1 = 2, FD1 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_enable = 1'b0;
  logic       write = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [8:0] din = '0;

  logic       txd0, tbr0, busy0, ovr0;
  logic [2:0] cnt0;
  logic       txd1, tbr1, busy1, ovr1;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  spart_tx_param #(
    .DATA_BITS   (DB0),
    .PARITY_MODE (PM0),
    .STOP_BITS   (SB0),
    .FIFO_DEPTH  (FD0)
  ) dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_enable   (tx_enable),
    .write       (write),
    .tx_in       (din[7:0]),
    .clr_overrun (clr_overrun),
    .txd         (txd0),
    .tbr         (tbr0),
    .busy        (busy0),
    .fifo_count  (cnt0),
    .overrun     (ovr0)
  );

  spart_tx_param #(
    .DATA_BITS   (DB1),
    .PARITY_MODE (PM1),
    .STOP_BITS   (SB1),
    .FIFO_DEPTH  (FD1)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_enable   (tx_enable),
    .write       (write),
    .tx_in       (din[6:0]),
    .clr_overrun (clr_overrun),
    .txd         (txd1),
    .tbr         (tbr1),
    .busy        (busy1),
    .fifo_count  (cnt1),
    .overrun     (ovr1)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: a word list per instance plus the bit list of the frame on the line.
  int fq [2][16];
  int mcnt [2];
  int fbits [2][16];
  int flen [2];
  int fpos [2];
  int e_txd [2];
  int e_busy [2];
  int e_ovr [2];

  function automatic int c_db(int i);    return (i == 0) ? DB0 : DB1; endfunction
  function automatic int c_pm(int i);    return (i == 0) ? PM0 : PM1; endfunction
  function automatic int c_sb(int i);    return (i == 0) ? SB0 : SB1; endfunction
  function automatic int c_depth(int i); return (i == 0) ? FD0 : FD1; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; flen[i] = 0; fpos[i] = 0;
      e_txd[i] = 1; e_busy[i] = 0; e_ovr[i] = 0;
    end
  endtask

  task automatic build_frame(input int i, input int d);
    int len;
    int par;
    len = 0;
    par = 0;
    fbits[i][len] = 0; len++;
    for (int k = 0; k < c_db(i); k++) begin
      fbits[i][len] = (d >> k) & 1; len++;
      par = par ^ ((d >> k) & 1);
    end
    if (c_pm(i) != 0) begin
      fbits[i][len] = (c_pm(i) == 2) ? (par ^ 1) : par; len++;
    end
    for (int k = 0; k < c_sb(i); k++) begin
      fbits[i][len] = 1; len++;
    end
    flen[i] = len;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int n;
      n = mcnt[i];
      if (tx_enable) begin
        if (fpos[i] < flen[i]) begin
          e_txd[i] = fbits[i][fpos[i]];
          fpos[i]++;
          e_busy[i] = 1;
        end else if (n > 0) begin
          build_frame(i, fq[i][0]);
          for (int k = 0; k < mcnt[i] - 1; k++) fq[i][k] = fq[i][k+1];
          mcnt[i]--;
          e_txd[i] = fbits[i][0];
          fpos[i] = 1;
          e_busy[i] = 1;
        end else begin
          e_txd[i] = 1;
          e_busy[i] = 0;
        end
      end
      if (write && n < c_depth(i)) begin
        fq[i][mcnt[i]] = int'(din) & ((1 << c_db(i)) - 1);
        mcnt[i]++;
      end
      if (write && n == c_depth(i)) e_ovr[i] = 1;
      else if (clr_overrun) e_ovr[i] = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    int a_txd [2], a_busy [2], a_cnt [2], a_tbr [2], a_ovr [2];
    @(posedge clk);
    forever begin
      @(negedge clk);
      a_txd[0] = int'(txd0);  a_busy[0] = int'(busy0); a_cnt[0] = int'(cnt0);
      a_tbr[0] = int'(tbr0);  a_ovr[0] = int'(ovr0);
      a_txd[1] = int'(txd1);  a_busy[1] = int'(busy1); a_cnt[1] = int'(cnt1);
      a_tbr[1] = int'(tbr1);  a_ovr[1] = int'(ovr1);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("dut%0d txd @%0t", i, $time), a_txd[i], e_txd[i]);
        chk($sformatf("dut%0d busy @%0t", i, $time), a_busy[i], e_busy[i]);
        chk($sformatf("dut%0d fifo_count @%0t", i, $time), a_cnt[i], mcnt[i]);
        chk($sformatf("dut%0d tbr @%0t", i, $time), a_tbr[i], int'(mcnt[i] < c_depth(i)));
        chk($sformatf("dut%0d overrun @%0t", i, $time), a_ovr[i], e_ovr[i]);
      end
    end
  end

  task automatic step(input logic t, input logic w, input int d, input logic c);
    tx_enable = t;
    write = w;
    din = 9'(d);
    clr_overrun = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400; k++) begin
      if (!busy0 && !busy1 && cnt0 == 0 && cnt1 == 0) break;
      step(1'b1, 1'b0, 0, 1'b0);
    end
    chk("drain within budget", int'(k < 400), 1);
  endtask

  initial begin
    logic [0:9]  exp_a;
    logic [0:10] exp_b;
    logic [0:20] exp_c;
    exp_a = 10'b0010001001;
    exp_b = 11'b01010101111;
    exp_c = 21'b0101001011_0001111001_1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset txd", int'(txd0), 1);
    chk("reset tbr", int'(tbr0), 1);
    chk("reset busy", int'(busy0), 0);
    chk("reset fifo_count", int'(cnt0), 0);
    chk("reset overrun", int'(ovr0), 0);

    // 0x22, 8N1, tick every 4 clocks
    step(1'b0, 1'b1, 'h22, 1'b0);
    chk("0x22 count after write", int'(cnt0), 1);
    for (int t = 0; t < 10; t++) begin
      repeat (3) step(1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      chk($sformatf("0x22 bit %0d", t), int'(txd0), int'(exp_a[t]));
      chk($sformatf("0x22 busy %0d", t), int'(busy0), 1);
    end
    repeat (3) step(1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("0x22 idle txd", int'(txd0), 1);
    chk("0x22 idle busy", int'(busy0), 0);
    drain();

    // 0x55, 7 data bits, odd parity, 2 stop bits
    step(1'b0, 1'b1, 'h55, 1'b0);
    for (int t = 0; t < 11; t++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
      chk($sformatf("7O2 0x55 bit %0d", t), int'(txd1), int'(exp_b[t]));
    end
    drain();

    // back-to-back frames with tx_enable held high
    step(1'b0, 1'b1, 'hA5, 1'b0);
    step(1'b0, 1'b1, 'h3C, 1'b0);
    for (int t = 0; t < 21; t++) begin
      step(1'b1, 1'b0, 0, 1'b0);
      chk($sformatf("b2b bit %0d", t), int'(txd0), int'(exp_c[t]));
    end
    drain();

    // overflow: five writes without ticks
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 'h11 * (k + 1), 1'b0);
    chk("full count", int'(cnt0), 4);
    chk("full tbr", int'(tbr0), 0);
    chk("full overrun", int'(ovr0), 1);
    chk("full count depth2", int'(cnt1), 2);
    chk("full overrun depth2", int'(ovr1), 1);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("overrun cleared", int'(ovr0), 0);
    chk("overrun cleared depth2", int'(ovr1), 0);
    drain();

    // write and tick in the same cycle on an empty FIFO
    step(1'b1, 1'b1, 'h0F, 1'b0);
    chk("same-cycle txd", int'(txd0), 1);
    chk("same-cycle busy", int'(busy0), 0);
    chk("same-cycle count", int'(cnt0), 1);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("same-cycle start", int'(txd0), 0);
    drain();

    // asynchronous reset during data bit 3
    step(1'b0, 1'b1, 'hFF, 1'b0);
    step(1'b0, 1'b1, 'h81, 1'b0);
    repeat (5) step(1'b1, 1'b0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort txd", int'(txd0), 1);
    chk("abort count", int'(cnt0), 0);
    chk("abort busy", int'(busy0), 0);
    chk("abort count depth2", int'(cnt1), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) step(1'b1, 1'b0, 0, 1'b0);
    chk("after abort txd", int'(txd0), 1);
    chk("after abort busy", int'(busy0), 0);

    // randomized traffic with bursts of continuous ticks
    for (int k = 0; k < 3000; k++) begin
      logic t;
      t = ((k % 500) < 100) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
      if (k == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step(t, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 511)),
           1'($urandom_range(0, 15) == 0));
    end
    drain();
    step(1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spart_tx_param.md
# spart_tx_param

Parametrised SPART transmitter: buffers outgoing bytes in an internal FIFO and serialises them LSB-first onto `txd` as UART frames with configurable data width, parity and stop bits. One bit is emitted per baud tick (`tx_enable`) from the SPART baud generator. Sits between the SPART bus interface (writes via `write`/`tx_in`) and the pad. Adds back-to-back frames, write buffering independent of the tick, and overrun reporting.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal 5..9
- `PARITY_MODE`, 0, 0 = none, 1 = even, 2 = odd
- `STOP_BITS`, 1, stop bits per frame; legal 1..2
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, >= 2
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `tx_enable`  in  1  baud tick, one-cycle pulse; one bit period per pulse
- `write`  in  1  push `tx_in` into FIFO
- `tx_in`  in  DATA_BITS  data word
- `clr_overrun`  in  1  clears `overrun`
- `txd`  out  1  serial line, idle high
- `tbr`  out  1  transmit buffer ready = FIFO not full
- `busy`  out  1  a frame is on the line (state != IDLE)
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- `overrun`  out  1  sticky: write attempted while full

## Operation
- Reset values: `txd`=1, `tbr`=1, `busy`=0, `fifo_count`=0, `overrun`=0, state IDLE, FIFO empty.
- Write: accepted on any cycle with `write` && `tbr`, independent of `tx_enable`. `write` while full: data dropped, `overrun` set. `clr_overrun` clears; simultaneous set and clear -> set wins.
- Parity computed at FIFO pop: even = XOR of data, odd = XNOR of data.
- FSM advances only on cycles with `tx_enable`=1; `txd` registered, changes only on those cycles:
  - IDLE: FIFO non-empty -> pop head into shift reg, `txd`<=0, -> START. Else `txd`<=1.
  - START: `txd`<=data[0], bit_cnt<=1, -> DATA.
  - DATA: bit_cnt<DATA_BITS -> `txd`<=next data bit, bit_cnt++. Else parity on -> `txd`<=parity, -> PARITY; parity off -> `txd`<=1, stop_cnt<=1, -> STOP.
  - PARITY: `txd`<=1, stop_cnt<=1, -> STOP.
  - STOP: stop_cnt<STOP_BITS -> stop_cnt++. Else FIFO non-empty -> pop, `txd`<=0, -> START (no idle gap); else -> IDLE, `txd` stays 1.
- Frame = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS ticks.

## Timing
- `tbr`, `fifo_count` reflect the registered FIFO pointers: update the cycle after a push/pop.
- Write-to-start latency from IDLE: start bit driven on first tick strictly after the write cycle. Write and tick in the same cycle with FIFO empty -> pop not seen; start on next tick.
- Full FIFO, write and pop same cycle: write rejected (fullness evaluated before pop), `overrun` set.
- Empty FIFO, push and pop same cycle impossible (pop requires non-empty pre-cycle state).
- `tx_enable` held high continuously: one bit per clock, legal.
- `rst_n` asserted mid-frame: immediate abort, `txd`=1, FIFO flushed, all outputs to reset values; no partial frame resumes.
- Pointer wrap: modulo FIFO_DEPTH; count distinguishes full from empty.

## Structure
- Package `spart_pkg`: parity mode constants (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`), TX state enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `spart_sync_fifo` (params WIDTH, DEPTH; push/pop/full/empty/count); reused later by the receiver.
- Top holds FSM, shift register, bit/stop counters, parity, overrun.

## Test plan
- Defaults, write 0x22 once, tick every 4 clks -> `txd` 0,0,1,0,0,0,1,0,0,1 across 10 ticks, then idle high; `busy` high for 10 ticks.
- DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2, write 0x55 -> 0,1,0,1,0,1,0,1,0,1,1 (parity 0); with PARITY_MODE=2 parity bit 1.
- Write 0xA5, 0x3C back-to-back -> second start bit on the tick immediately after first stop bit; no extra idle tick.
- FIFO_DEPTH=4, five writes with no ticks -> `fifo_count`=4, `tbr`=0, `overrun`=1, fifth byte never sent; `clr_overrun` -> 0.
- Write and tick same cycle on empty FIFO -> `txd` stays 1 that tick, start bit on next tick.
- Assert `rst_n` low during data bit 3 -> `txd`=1 asynchronously, `fifo_count`=0, `busy`=0; after release, idle until new write.
